// File: rtl/ppu_table_arbiter.sv
// Arbitrates the single-port PPU table memories between scanner reads (always win)
// and queued host writes, with an optional hold that drains the queue only during vblank.
module ppu_table_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_chipselect,
   input  logic                          i_write,
   input  logic [15:0]                   i_address,
   input  logic [DATA_W-1:0]             i_writedata,
   output logic                          o_waitrequest,
   input  logic                          i_vblank,
   input  logic                          i_hold_en,
   input  logic                          i_scan_req,
   input  logic [1:0]                    i_scan_table,
   input  logic [ADDR_W-1:0]             i_scan_addr,
   output logic                          o_scan_rvalid,
   output logic [2:0]                    o_mem_we,
   output logic [ADDR_W-1:0]             o_mem_addr,
   output logic [DATA_W-1:0]             o_mem_wdata,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [1:0]        tbl;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ent_t;

   typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

   state_t            r_state, w_state_nxt;
   ent_t              r_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic              r_scan_rvalid;
   logic              w_push, w_pop, w_empty;
   ent_t              w_head, w_in;
   logic              w_unused;

   // The scanner only qualifies its own request; every table sees the shared address.
   assign w_unused = ^{i_scan_table, i_address[15:10]};

   assign w_empty       = (r_level == '0);
   assign o_waitrequest = (r_level == LVL_W'(FIFO_DEPTH));
   assign o_fifo_level  = r_level;
   assign o_scan_rvalid = r_scan_rvalid;

   assign w_push = i_chipselect & i_write & ~o_waitrequest;
   assign w_pop  = ~i_scan_req & ~w_empty & (r_state != HOLD);
   assign w_head = r_q[r_rd_ptr];

   // Code 2'b11 aliases the color table, so fold it at enqueue time.
   always_comb begin
      w_in      = '0;
      w_in.tbl  = (i_address[9:8] == 2'b11) ? 2'b10 : i_address[9:8];
      w_in.addr = i_address[ADDR_W-1:0];
      w_in.data = i_writedata;
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_q[r_wr_ptr] <= w_in;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_level       <= '0;
         r_scan_rvalid <= 1'b0;
         r_state       <= RUN;
      end else begin
         r_scan_rvalid <= i_scan_req;
         r_state       <= w_state_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_level <= r_level + 1'b1;
         else if (w_pop && !w_push) r_level <= r_level - 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (i_hold_en && !i_vblank) w_state_nxt = HOLD;
         HOLD: begin
            if (!i_hold_en)    w_state_nxt = RUN;
            else if (i_vblank) w_state_nxt = FLUSH;
         end
         FLUSH:   if (w_empty || !i_vblank) w_state_nxt = i_hold_en ? HOLD : RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   // Memory port mux: scanner address wins, then the queue head, else idle zeros.
   always_comb begin
      o_mem_we    = 3'b000;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (i_scan_req) begin
         o_mem_addr = i_scan_addr;
      end else if (w_pop) begin
         o_mem_addr  = w_head.addr;
         o_mem_wdata = w_head.data;
         case (w_head.tbl)
            2'b00:   o_mem_we = 3'b001;
            2'b01:   o_mem_we = 3'b010;
            default: o_mem_we = 3'b100;
         endcase
      end
   end

endmodule
